// File: rtl/seq_mag_comparator_if.sv
// Handshake bundle for the sequential magnitude comparator: operand channel
// (valid/ready + a/b/signed_mode) and result channel (valid/ready + gt/eq/lt).
interface seq_mag_comparator_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_mode;
   logic             out_valid;
   logic             out_ready;
   logic             gt;
   logic             eq;
   logic             lt;

   // master: operand producer and result consumer; slave: the comparator
   modport master (
      output in_valid, a, b, signed_mode, out_ready,
      input  in_ready, out_valid, gt, eq, lt
   );

   modport slave (
      input  in_valid, a, b, signed_mode, out_ready,
      output in_ready, out_valid, gt, eq, lt
   );
endinterface

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per clock with early
// exit on the first differing chunk; signed mode via offset-binary MSB flip.
module seq_mag_comparator #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 2
) (
   input logic                 clk,
   input logic                 rst,
   seq_mag_comparator_if.slave bus_if
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = $clog2(NCHUNK + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             gt_q, gt_d;
   logic             eq_q, eq_d;
   logic             lt_q, lt_d;

   logic [CHUNK-1:0] chunk_a;
   logic [CHUNK-1:0] chunk_b;
   logic [WIDTH-1:0] flip;

   assign chunk_a = sa_q[WIDTH-1 -: CHUNK];
   assign chunk_b = sb_q[WIDTH-1 -: CHUNK];
   assign flip    = bus_if.signed_mode ? MSB_MASK : '0;

   always_comb begin
      state_d     = state_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      gt_d        = gt_q;
      eq_d        = eq_q;
      lt_d        = lt_q;

      case (state_q)
         IDLE: begin
            if (bus_if.in_valid && in_ready_q) begin
               sa_d       = bus_if.a ^ flip;
               sb_d       = bus_if.b ^ flip;
               cnt_d      = CNT_W'(NCHUNK);
               gt_d       = 1'b0;
               eq_d       = 1'b0;
               lt_d       = 1'b0;
               in_ready_d = 1'b0;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            if (chunk_a > chunk_b) begin
               gt_d        = 1'b1;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else if (chunk_a < chunk_b) begin
               lt_d        = 1'b1;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else if (cnt_q == CNT_W'(1)) begin
               eq_d        = 1'b1;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               sa_d  = sa_q << CHUNK;
               sb_d  = sb_q << CHUNK;
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            // No accept here: in_ready rises only as DONE is left.
            if (bus_if.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sa_q        <= '0;
         sb_q        <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         gt_q        <= 1'b0;
         eq_q        <= 1'b0;
         lt_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         sa_q        <= sa_d;
         sb_q        <= sb_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         gt_q        <= gt_d;
         eq_q        <= eq_d;
         lt_q        <= lt_d;
      end
   end

   assign bus_if.in_ready  = in_ready_q;
   assign bus_if.out_valid = out_valid_q;
   assign bus_if.gt        = gt_q;
   assign bus_if.eq        = eq_q;
   assign bus_if.lt        = lt_q;
endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench for seq_mag_comparator (16/2 instance) plus an exhaustive
// sweep of a 4/1 instance against a behavioural signed/unsigned compare.
module tb_seq_mag_comparator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   errs    = 0;

   always #5 clk = ~clk;

   seq_mag_comparator_if #(.WIDTH(16)) if0 ();
   seq_mag_comparator_if #(.WIDTH(4))  if1 ();

   seq_mag_comparator #(.WIDTH(16), .CHUNK(2)) u0 (
      .clk    (clk),
      .rst    (rst),
      .bus_if (if0)
   );

   seq_mag_comparator #(.WIDTH(4), .CHUNK(1)) u1 (
      .clk    (clk),
      .rst    (rst),
      .bus_if (if1)
   );

   localparam logic [2:0] R_GT = 3'b100;
   localparam logic [2:0] R_EQ = 3'b010;
   localparam logic [2:0] R_LT = 3'b001;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---- 16-bit instance helpers (called #1 after a rising edge) ----
   task automatic start0(input logic [15:0] av, input logic [15:0] bv, input logic m);
      if0.a           = av;
      if0.b           = bv;
      if0.signed_mode = m;
      if0.in_valid    = 1'b1;
      @(posedge clk); #1;
      if0.in_valid    = 1'b0;
      if0.a           = ~av;
      if0.b           = ~bv;
      if0.signed_mode = ~m;
   endtask

   task automatic wait0(output int lat);
      lat = 0;
      while (!if0.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic consume0(input string tag);
      if0.out_ready = 1'b1;
      @(posedge clk); #1;
      if0.out_ready = 1'b0;
      check({tag, "_ovalid_after"}, 32'(if0.out_valid), 32'd0);
      check({tag, "_irdy_after"}, 32'(if0.in_ready), 32'd1);
   endtask

   task automatic run0(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic m, input logic [2:0] exp_res, input int exp_lat);
      int lat;
      start0(av, bv, m);
      check({tag, "_irdy_busy"}, 32'(if0.in_ready), 32'd0);
      wait0(lat);
      $display("vec %s a=%h b=%h s=%0d -> gt/eq/lt=%b lat=%0d", tag, av, bv, m,
               {if0.gt, if0.eq, if0.lt}, lat);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_res"}, 32'({if0.gt, if0.eq, if0.lt}), 32'(exp_res));
      check({tag, "_irdy_done"}, 32'(if0.in_ready), 32'd0);
      consume0(tag);
      check({tag, "_retained"}, 32'({if0.gt, if0.eq, if0.lt}), 32'(exp_res));
   endtask

   // ---- 4-bit instance sweep helper ----
   task automatic run1(input logic [3:0] av, input logic [3:0] bv, input logic m);
      int         lat;
      int         exp_lat;
      logic [2:0] exp_res;
      logic [3:0] x;
      logic signed [3:0] sa;
      logic signed [3:0] sb;
      sa = av;
      sb = bv;
      if (m) exp_res = (sa > sb) ? R_GT : (sa < sb) ? R_LT : R_EQ;
      else   exp_res = (av > bv) ? R_GT : (av < bv) ? R_LT : R_EQ;
      x       = av ^ bv;
      exp_lat = 4;
      for (int k = 0; k < 4; k++) if (x[k]) exp_lat = 4 - k;

      if1.a           = av;
      if1.b           = bv;
      if1.signed_mode = m;
      if1.in_valid    = 1'b1;
      @(posedge clk); #1;
      if1.in_valid    = 1'b0;
      lat = 0;
      while (!if1.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("sw_%h_%h_%0d_res", av, bv, m), 32'({if1.gt, if1.eq, if1.lt}), 32'(exp_res));
      check($sformatf("sw_%h_%h_%0d_lat", av, bv, m), 32'(lat), 32'(exp_lat));
      if1.out_ready = 1'b1;
      @(posedge clk); #1;
      if1.out_ready = 1'b0;
   endtask

   initial begin
      int  lat;
      bit  seen;
      if0.in_valid = 1'b0; if0.out_ready = 1'b0; if0.a = '0; if0.b = '0; if0.signed_mode = 1'b0;
      if1.in_valid = 1'b0; if1.out_ready = 1'b0; if1.a = '0; if1.b = '0; if1.signed_mode = 1'b0;

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_irdy", 32'(if0.in_ready), 32'd1);
      check("rst_ovalid", 32'(if0.out_valid), 32'd0);
      check("rst_res", 32'({if0.gt, if0.eq, if0.lt}), 32'd0);

      // Directed vectors
      run0("eq_1234",     16'h1234, 16'h1234, 1'b0, R_EQ, 8);
      run0("u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, R_GT, 1);
      run0("s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, R_LT, 1);
      run0("u_0100_0000", 16'h0100, 16'h0000, 1'b0, R_GT, 4);
      run0("u_0005_0006", 16'h0005, 16'h0006, 1'b0, R_LT, 8);
      run0("s_ffff_fffe", 16'hFFFF, 16'hFFFE, 1'b1, R_GT, 8);
      run0("s_0000_ffff", 16'h0000, 16'hFFFF, 1'b1, R_GT, 1);

      // Backpressure: 0x00FF vs 0x0F00 differs at chunk 3 -> lt
      start0(16'h00FF, 16'h0F00, 1'b0);
      wait0(lat);
      check("bp_lat", 32'(lat), 32'd3);
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            if0.a = 16'hFFFF; if0.b = 16'h0000; if0.signed_mode = 1'b0;
            if0.in_valid = 1'b1;
         end
         @(posedge clk); #1;
         if0.in_valid = 1'b0;
         $display("vec bp hold %0d ovalid=%0d irdy=%0d gt/eq/lt=%b", c, if0.out_valid,
                  if0.in_ready, {if0.gt, if0.eq, if0.lt});
         check($sformatf("bp_hold%0d_ovalid", c), 32'(if0.out_valid), 32'd1);
         check($sformatf("bp_hold%0d_irdy", c), 32'(if0.in_ready), 32'd0);
         check($sformatf("bp_hold%0d_res", c), 32'({if0.gt, if0.eq, if0.lt}), 32'(R_LT));
      end
      consume0("bp");
      check("bp_retained", 32'({if0.gt, if0.eq, if0.lt}), 32'(R_LT));
      // The ignored pulse must not have queued a compare
      repeat (3) @(posedge clk);
      #1 check("bp_no_phantom", 32'(if0.out_valid), 32'd0);

      // Reset during BUSY at T0+3
      start0(16'h0001, 16'h0000, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      $display("vec mid_rst irdy=%0d ovalid=%0d gt/eq/lt=%b", if0.in_ready, if0.out_valid,
               {if0.gt, if0.eq, if0.lt});
      check("mrst_irdy", 32'(if0.in_ready), 32'd1);
      check("mrst_ovalid", 32'(if0.out_valid), 32'd0);
      check("mrst_res", 32'({if0.gt, if0.eq, if0.lt}), 32'd0);
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (if0.out_valid) seen = 1'b1;
      end
      check("mrst_no_result", 32'(seen), 32'd0);
      run0("post_rst", 16'h0001, 16'h0002, 1'b0, R_LT, 8);

      // Exhaustive 4-bit bit-serial sweep
      for (int m = 0; m < 2; m++)
         for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
               run1(4'(ai), 4'(bi), 1'(m));
      $display("vec sweep4 done");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
